// File: rtl/fifo_pkg.sv
// Shared types and constants for the asynchronous FIFO read-side logic.
package fifo_pkg;

  // Output buffer occupancy of the read-side drain engine.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } rd_state_t;

  localparam int unsigned RD_STAT_W = 32;

endpackage : fifo_pkg

// File: rtl/rd_skid_buf.sv
// Two-entry output buffer: head register drives the stream, tail register
// absorbs the word already popped from the FIFO when downstream stalls.
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  output logic             full
);

  rd_state_t        state_q;
  rd_state_t        state_d;
  logic             valid_q;
  logic             full_q;
  logic             pop;
  logic             load_head;
  logic             load_tail;
  logic             shift_tail;
  logic [DSIZE-1:0] head_q;
  logic [DSIZE-1:0] tail_q;

  assign pop = valid_q && m_ready;

  // Occupancy register, with valid/full flags registered alongside it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
      full_q  <= (state_d == TWO);
    end
  end

  // Next occupancy from push/pop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = TWO;
        else if (!push && pop) state_d = EMPTY;
      end
      TWO:     if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Datapath steering: which register takes the pushed word, and when the tail shifts up.
  always_comb begin
    load_head  = 1'b0;
    load_tail  = 1'b0;
    shift_tail = 1'b0;
    unique case (state_q)
      EMPTY: load_head = push;
      ONE: begin
        load_head = push && pop;
        load_tail = push && !pop;
      end
      TWO:     shift_tail = pop;
      default: ;
    endcase
  end

  // Head and tail data registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head)       head_q <= push_data;
      else if (shift_tail) head_q <= tail_q;
      if (load_tail)       tail_q <= push_data;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = head_q;
  assign full    = full_q;

endmodule : rd_skid_buf

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pops the async FIFO and presents a valid/ready stream.
// Optional handshake counter enabled by defining FIFO_RD_STAT_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = 8
) (
  input  logic                 r_clk,
  input  logic                 rstn,
  input  logic                 rempty,
  input  logic [DSIZE-1:0]     rdata,
  output logic                 rinc,
  output logic                 m_valid,
  output logic [DSIZE-1:0]     m_data,
  input  logic                 m_ready
`ifdef FIFO_RD_STAT_EN
  ,
  output logic [RD_STAT_W-1:0] rd_words
`endif
);

  logic full;

  rd_skid_buf #(
    .DSIZE(DSIZE)
  ) u_buf (
    .clk      (r_clk),
    .rstn     (rstn),
    .push     (rinc),
    .push_data(rdata),
    .m_ready  (m_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .full     (full)
  );

  // Pop whenever the FIFO has data and a buffer slot is free; held off during reset.
  assign rinc = rstn && !rempty && !full;

`ifdef FIFO_RD_STAT_EN
  logic [RD_STAT_W-1:0] rd_words_q;

  // Saturating count of completed output handshakes.
  always_ff @(posedge r_clk or negedge rstn) begin
    if (!rstn) begin
      rd_words_q <= '0;
    end else if (m_valid && m_ready && (rd_words_q != '1)) begin
      rd_words_q <= rd_words_q + RD_STAT_W'(1);
    end
  end

  assign rd_words = rd_words_q;
`endif

endmodule : fifo_rd_stream

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: cycle table after reset, directed corner sequences,
// and randomized traffic against a queue-based FIFO/buffer model.
module tb_fifo_rd_stream;

  logic       r_clk = 1'b0;
  logic       rstn;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
`ifdef FIFO_RD_STAT_EN
  logic [31:0] rd_words;
`endif

  fifo_rd_stream #(.DSIZE(8)) u_dut (
    .r_clk   (r_clk),
    .rstn    (rstn),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready)
`ifdef FIFO_RD_STAT_EN
    ,
    .rd_words(rd_words)
`endif
  );

  always #5 r_clk = ~r_clk;

  typedef struct {
    logic       rempty;
    logic [7:0] rdata;
    logic       rdy;
    logic       e_rinc;
    logic       e_mv;
    logic       chk_d;
    logic [7:0] e_md;
  } vec_t;

  vec_t tv[9];

  int          n_checks = 0;
  int          n_err    = 0;
  logic [7:0]  fifo_q[$];
  logic [7:0]  buf_q[$];
  logic [7:0]  out_log[$];
  logic [7:0]  sent[$];
  int          out_cyc[$];
  int          cyc = 0;
  int          dut_pops = 0;
  int unsigned hs_total = 0;
  bit          hold_empty = 1'b0;
  bit          rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, check against the model, advance the model at posedge.
  task automatic step();
    logic exp_rinc;
    logic exp_mv;
    logic do_pop;
    @(negedge r_clk);
    m_ready = rdy;
    rempty  = hold_empty || (fifo_q.size() == 0);
    rdata   = rempty ? 8'h00 : fifo_q[0];
    #1;
    exp_rinc = rstn && !rempty && (buf_q.size() < 2);
    exp_mv   = (buf_q.size() > 0);
    chk("rinc", 32'(rinc), 32'(exp_rinc));
    chk("m_valid", 32'(m_valid), 32'(exp_mv));
    if (exp_mv) chk("m_data", 32'(m_data), 32'(buf_q[0]));
    if (rinc === 1'b1) dut_pops++;
    do_pop = exp_mv && rdy;
    @(posedge r_clk);
    cyc++;
    if (do_pop) begin
      out_log.push_back(buf_q.pop_front());
      out_cyc.push_back(cyc);
      hs_total++;
    end
    if (exp_rinc) buf_q.push_back(fifo_q.pop_front());
  endtask

  task automatic clear_logs();
    out_log.delete();
    out_cyc.delete();
    sent.delete();
    dut_pops = 0;
  endtask

  task automatic check_order(input string name);
    chk({name, "_count"}, 32'(out_log.size()), 32'(sent.size()));
    for (int i = 0; i < sent.size(); i++) begin
      if (i < out_log.size()) chk({name, "_word"}, 32'(out_log[i]), 32'(sent[i]));
    end
  endtask

  initial begin
    // cycle table, starting one cycle after reset release (buffer holds 0x11)
    tv[0] = '{1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
    tv[1] = '{1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
    tv[2] = '{1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11};
    tv[3] = '{1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22};
    tv[4] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33};
    tv[5] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[6] = '{1'b0, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[7] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44};
    tv[8] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44};

    // Reset held with a non-empty FIFO: nothing popped, outputs cleared.
    rstn = 1'b0; rempty = 1'b0; rdata = 8'hEE; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge r_clk);
      #1;
      chk("rst_rinc", 32'(rinc), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
    end
`ifdef FIFO_RD_STAT_EN
    chk("rst_rd_words", rd_words, 32'd0);
`endif

    // Release: first pop on the first edge after deassertion.
    @(negedge r_clk);
    rstn = 1'b1; rempty = 1'b0; rdata = 8'h11; m_ready = 1'b0;
    #1;
    chk("rel_rinc", 32'(rinc), 32'd1);
    chk("rel_m_valid", 32'(m_valid), 32'd0);

    for (int i = 0; i < 9; i++) begin
      @(negedge r_clk);
      rempty = tv[i].rempty; rdata = tv[i].rdata; m_ready = tv[i].rdy;
      #1;
      chk($sformatf("tv%0d_rinc", i), 32'(rinc), 32'(tv[i].e_rinc));
      chk($sformatf("tv%0d_m_valid", i), 32'(m_valid), 32'(tv[i].e_mv));
      if (tv[i].chk_d) chk($sformatf("tv%0d_m_data", i), 32'(m_data), 32'(tv[i].e_md));
    end
    hs_total = 4;

    // Fifth handshake.
    clear_logs();
    fifo_q.push_back(8'h55); sent.push_back(8'h55);
    rdy = 1'b1; hold_empty = 1'b0;
    repeat (3) step();
    check_order("fifth");
`ifdef FIFO_RD_STAT_EN
    #1 chk("rd_words_5", rd_words, 32'd5);
`endif

    // Back-to-back stream 1..16 at full rate.
    clear_logs();
    for (int i = 1; i <= 16; i++) begin
      fifo_q.push_back(8'(i)); sent.push_back(8'(i));
    end
    rdy = 1'b1;
    repeat (20) step();
    check_order("stream");
    if (out_cyc.size() == 16) chk("stream_span", 32'(out_cyc[15] - out_cyc[0]), 32'd15);
    else chk("stream_span_count", 32'(out_cyc.size()), 32'd16);

    // Downstream stall: exactly two pops, head held, then in-order drain.
    clear_logs();
    fifo_q.push_back(8'hA5); fifo_q.push_back(8'h5A); fifo_q.push_back(8'h3C);
    sent.push_back(8'hA5); sent.push_back(8'h5A); sent.push_back(8'h3C);
    rdy = 1'b0;
    repeat (6) step();
    chk("stall_pops", 32'(dut_pops), 32'd2);
    chk("stall_head", 32'(m_data), 32'hA5);
    rdy = 1'b1;
    repeat (5) step();
    check_order("stall");

    // FIFO empty flag toggling every cycle.
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      fifo_q.push_back(8'(8'h80 + i)); sent.push_back(8'(8'h80 + i));
    end
    rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      hold_empty = i[0];
      step();
    end
    hold_empty = 1'b0;
    check_order("toggle");

    // Reset while full: buffered words discarded, next word fresh from the FIFO.
    clear_logs();
    fifo_q.push_back(8'hC1); fifo_q.push_back(8'hC2); fifo_q.push_back(8'hC3);
    rdy = 1'b0;
    repeat (3) step();
    @(negedge r_clk);
    #2;
    rstn = 1'b0; rempty = 1'b1;
    #1;
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_rinc", 32'(rinc), 32'd0);
    buf_q.delete(); fifo_q.delete(); hs_total = 0;
    repeat (2) @(negedge r_clk);
    rstn = 1'b1;
    fifo_q.push_back(8'h77); sent.push_back(8'h77);
    rdy = 1'b1;
    repeat (4) step();
    check_order("midrst");

    // Randomized traffic.
    clear_logs();
    for (int i = 0; i < 400; i++) begin
      rdy        = ($urandom_range(0, 3) != 0);
      hold_empty = ($urandom_range(0, 4) == 0);
      if (($urandom_range(0, 2) != 0) && (fifo_q.size() < 8)) begin
        logic [7:0] w;
        w = 8'($urandom);
        fifo_q.push_back(w); sent.push_back(w);
      end
      step();
    end
    rdy = 1'b1; hold_empty = 1'b0;
    repeat (14) step();
    check_order("random");
`ifdef FIFO_RD_STAT_EN
    #1 chk("rd_words_random", rd_words, 32'(hs_total));

    // Saturation from a preloaded counter.
    @(negedge r_clk);
    force u_dut.rd_words_q = 32'hFFFF_FFFE;
    #1 release u_dut.rd_words_q;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      fifo_q.push_back(8'(8'h90 + i)); sent.push_back(8'(8'h90 + i));
    end
    repeat (5) step();
    check_order("sat");
    #1 chk("rd_words_sat", rd_words, 32'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_fifo_rd_stream
